// File: rtl/flg_offset_gen.sv
// Flag-offset generator: ANDs one activation and one weight flag vector and
// emits one beat per matched position, each carrying the absolute
// compressed-buffer addresses of the matching activation and weight.
// Running bases carry addresses across the vectors of a channel group.
module flg_offset_gen #(
  parameter int unsigned FLAG_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic [FLAG_WIDTH-1:0]         in_flg_act,
  input  logic [FLAG_WIDTH-1:0]         in_flg_wei,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr_act,
  output logic [ADDR_WIDTH-1:0]         out_addr_wei,
  output logic [$clog2(FLAG_WIDTH)-1:0] out_pos,
  output logic                          out_last,
  output logic                          out_empty
);

  localparam int unsigned PW = $clog2(FLAG_WIDTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [FLAG_WIDTH-1:0] act_q, act_d;
  logic [FLAG_WIDTH-1:0] wei_q, wei_d;
  logic [FLAG_WIDTH-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] base_cur_act_q, base_cur_act_d;
  logic [ADDR_WIDTH-1:0] base_cur_wei_q, base_cur_wei_d;
  logic [ADDR_WIDTH-1:0] base_next_act_q, base_next_act_d;
  logic [ADDR_WIDTH-1:0] base_next_wei_q, base_next_wei_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_act_q, out_addr_act_d;
  logic [ADDR_WIDTH-1:0] out_addr_wei_q, out_addr_wei_d;
  logic [PW-1:0]         out_pos_q, out_pos_d;
  logic                  out_last_q, out_last_d;
  logic                  out_empty_q, out_empty_d;

  logic                  free;
  logic [PW-1:0]         p_sel;
  logic [FLAG_WIDTH-1:0] below_m;
  logic [ADDR_WIDTH-1:0] in_base_act;
  logic [ADDR_WIDTH-1:0] in_base_wei;

  function automatic logic [CW-1:0] popcount(input logic [FLAG_WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < FLAG_WIDTH; i++) cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  assign free      = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE);

  // Pick the next match position in scan order and mask of positions below it.
  // The loop order makes the last hit win: high-to-low yields the lowest set
  // bit, low-to-high yields the highest.
  always_comb begin
    p_sel   = '0;
    below_m = '0;
    for (int unsigned i = 0; i < FLAG_WIDTH; i++) begin
      if (mask_q[MSB_FIRST ? i : FLAG_WIDTH - 1 - i])
        p_sel = PW'(MSB_FIRST ? i : FLAG_WIDTH - 1 - i);
    end
    for (int unsigned i = 0; i < FLAG_WIDTH; i++) below_m[i] = (i < 32'(p_sel));
  end

  // Group bases for a newly offered vector.
  always_comb begin
    in_base_act = in_first ? '0 : base_next_act_q;
    in_base_wei = in_first ? '0 : base_next_wei_q;
  end

  // Next-state, latched-vector and output-register computation.
  always_comb begin
    state_d         = state_q;
    act_d           = act_q;
    wei_d           = wei_q;
    mask_d          = mask_q;
    base_cur_act_d  = base_cur_act_q;
    base_cur_wei_d  = base_cur_wei_q;
    base_next_act_d = base_next_act_q;
    base_next_wei_d = base_next_wei_q;
    out_valid_d     = out_valid_q;
    out_addr_act_d  = out_addr_act_q;
    out_addr_wei_d  = out_addr_wei_q;
    out_pos_d       = out_pos_q;
    out_last_d      = out_last_q;
    out_empty_d     = out_empty_q;
    unique case (state_q)
      IDLE: begin
        if (free) out_valid_d = 1'b0;
        if (in_valid) begin
          act_d           = in_flg_act;
          wei_d           = in_flg_wei;
          mask_d          = in_flg_act & in_flg_wei;
          base_cur_act_d  = in_base_act;
          base_cur_wei_d  = in_base_wei;
          base_next_act_d = in_base_act + ADDR_WIDTH'(popcount(in_flg_act));
          base_next_wei_d = in_base_wei + ADDR_WIDTH'(popcount(in_flg_wei));
          state_d         = SCAN;
        end
      end
      SCAN: begin
        if (free) begin
          out_valid_d = 1'b1;
          if (mask_q == '0) begin
            out_empty_d    = 1'b1;
            out_last_d     = 1'b1;
            out_pos_d      = '0;
            out_addr_act_d = '0;
            out_addr_wei_d = '0;
            state_d        = IDLE;
          end else begin
            mask_d         = mask_q;
            mask_d[p_sel]  = 1'b0;
            out_empty_d    = 1'b0;
            out_pos_d      = p_sel;
            out_addr_act_d = base_cur_act_q + ADDR_WIDTH'(popcount(act_q & below_m));
            out_addr_wei_d = base_cur_wei_q + ADDR_WIDTH'(popcount(wei_q & below_m));
            out_last_d     = (mask_d == '0);
            if (mask_d == '0) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      act_q           <= '0;
      wei_q           <= '0;
      mask_q          <= '0;
      base_cur_act_q  <= '0;
      base_cur_wei_q  <= '0;
      base_next_act_q <= '0;
      base_next_wei_q <= '0;
      out_valid_q     <= 1'b0;
      out_addr_act_q  <= '0;
      out_addr_wei_q  <= '0;
      out_pos_q       <= '0;
      out_last_q      <= 1'b0;
      out_empty_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      act_q           <= act_d;
      wei_q           <= wei_d;
      mask_q          <= mask_d;
      base_cur_act_q  <= base_cur_act_d;
      base_cur_wei_q  <= base_cur_wei_d;
      base_next_act_q <= base_next_act_d;
      base_next_wei_q <= base_next_wei_d;
      out_valid_q     <= out_valid_d;
      out_addr_act_q  <= out_addr_act_d;
      out_addr_wei_q  <= out_addr_wei_d;
      out_pos_q       <= out_pos_d;
      out_last_q      <= out_last_d;
      out_empty_q     <= out_empty_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr_act = out_addr_act_q;
  assign out_addr_wei = out_addr_wei_q;
  assign out_pos      = out_pos_q;
  assign out_last     = out_last_q;
  assign out_empty    = out_empty_q;

endmodule

// File: doc/flg_offset_gen.md
Name: flg_offset_gen

Overview:
- Parametrised successor to the single-vector flag-offset cell array.
- Accepts one activation-flag and one weight-flag bitmap per transaction, computes their AND (the match mask) and emits one beat per matched position, one per cycle, under valid/ready backpressure.
- Each beat carries the absolute compressed-buffer address of the matching nonzero activation and weight.
- Running bases carry addresses across consecutive vectors of a channel group. Sits between the flag fetch and the PE MAC operand read ports.

Parameters:
- FLAG_WIDTH, 32, bits per flag vector (≥2).
- ADDR_WIDTH, 12, width of the absolute compressed address outputs; arithmetic wraps modulo 2^ADDR_WIDTH.
- MSB_FIRST, 0, scan order: 0 emits matches lowest index first, 1 emits highest index first.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  flag vector offered.
- in_ready  out  1  block can accept a vector.
- in_first  in  1  vector starts a new group; bases restart at 0.
- in_flg_act  in  FLAG_WIDTH  activation nonzero flags.
- in_flg_wei  in  FLAG_WIDTH  weight nonzero flags.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts beat.
- out_addr_act  out  ADDR_WIDTH  absolute activation address.
- out_addr_wei  out  ADDR_WIDTH  absolute weight address.
- out_pos  out  clog2(FLAG_WIDTH)  bit position of the match.
- out_last  out  1  final beat of this vector.
- out_empty  out  1  vector had no matches; addresses are don't-care, so drive them 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All of the following clear to 0: out_valid, out_addr_*, out_pos, out_last, out_empty, latched flags, match mask, base_cur_*, base_next_*. in_ready=1 after reset releases.
- Reset mid-transaction discards the vector and any pending beat with no further outputs.
- States:
  - IDLE: in_ready=1.
  - SCAN: in_ready=0.
- Accept happens when in_valid&in_ready. On accept:
  - latch act, wei; mask M = act&wei;
  - base_cur = in_first ? 0 : base_next;
  - base_next = base_cur + popcount(in_flg_act) (weight side likewise, using in_flg_wei);
  - go to SCAN.
- Output register "free" = !out_valid | out_ready.
- In SCAN, when free:
  - If M==0: register one beat with out_empty=1, out_last=1, out_pos=0, addresses 0. Go to IDLE.
  - Else: p = lowest set bit of M (highest if MSB_FIRST).
    - out_addr_act = base_cur_act + popcount(act bits strictly below p).
    - out_addr_wei = base_cur_wei + popcount(wei bits strictly below p).
    - out_pos=p; clear M[p].
    - out_last=1 if M had exactly one bit set; then go to IDLE.
  - The addressing rule is independent of MSB_FIRST; only beat order changes.
- In SCAN, when not free: hold all outputs and M (no beat lost or duplicated).
- In IDLE, when free and no new beat: out_valid<=0.
- Latency: a vector accepted at edge T gives its first out_valid after edge T+1. Throughput is 1 beat/cycle. A vector with k≥1 matches yields exactly k beats; with 0 matches, exactly 1 empty beat.
- Overlap: in_ready rises the cycle after the last beat is registered, so a new vector can be accepted while that beat is still held by backpressure.
- Popcount and addition widths: popcount is clog2(FLAG_WIDTH)+1 bits, zero-extended. Sums are truncated to ADDR_WIDTH (wrap-around is legal and required).
- Outputs are stable while out_valid=1 and out_ready=0.

Test Plan:
- FLAG_WIDTH=8, MSB_FIRST=0, in_first=1, act=0xB6, wei=0x63, out_ready=1 -> beats (pos1, act0, wei1, last0), then (pos5, act3, wei2, last1) on consecutive cycles. First beat comes after the cycle following accept.
- Same vector, MSB_FIRST=1 -> beats (pos5, 3, 2, last0), then (pos1, 0, 1, last1).
- Second vector, in_first=0, act=0x01, wei=0x01 -> one beat (pos0, act5, wei4, last1), with bases 5/4 carried over. Repeat with in_first=1 -> (pos0, 0, 0).
- act=0xF0, wei=0x0F -> one beat with out_empty=1, out_last=1. in_ready is high again after it.
- Backpressure: hold out_ready=0 for 3 cycles during the first test -> first beat held stable. No second beat and no in_ready during the stall. Beats resume in order when out_ready is released.
- ADDR_WIDTH=4, feed four full 0xFF/0xFF vectors with in_first=0 -> addresses wrap after 15 to 0. Assert rst_n mid-scan -> out_valid=0 immediately, and the next vector starts at base 0.
